// File: rtl/conv1d_requant.sv
// Requantisation stage behind the conv1d PE chain: drops pipeline-fill psums,
// rounds/shifts each result to DW bits, applies the activation and saturates.
`ifndef WIDTH_DATA
`define WIDTH_DATA 16
`endif

module conv1d_requant #(
    parameter int DW = `WIDTH_DATA,
    parameter int K  = 3,
    parameter int LW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [LW-1:0]   frame_len_i,
    input  logic [4:0]      shift_i,
    input  logic [1:0]      act_mode_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2*DW-1:0] psum_in_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [DW-1:0]   out_data_o,
    output logic            out_last_o,
    output logic            busy_o
);

    localparam int PW = 2 * DW;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] WARM_LAST = CW'((K > 1) ? K - 2 : 0);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WARMUP = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] FIRST_STATE = (K > 1) ? S_WARMUP : S_RUN;

    localparam logic signed [PW-1:0] SAT_MAX = {{(DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(DW + 1){1'b1}}, {(DW - 1){1'b0}}};

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] warmCnt_q, warmCnt_d;
    logic [LW-1:0] runCnt_q, runCnt_d;
    logic [LW-1:0] lenCfg_q, lenCfg_d;
    logic [4:0]    shiftCfg_q, shiftCfg_d;
    logic [1:0]    actCfg_q, actCfg_d;

    logic                 s1Valid_q, s1Valid_d;
    logic signed [PW-1:0] s1Data_q, s1Data_d;
    logic                 s1Last_q, s1Last_d;
    logic                 s2Valid_q, s2Valid_d;
    logic [DW-1:0]        s2Data_q, s2Data_d;
    logic                 s2Last_q, s2Last_d;

    logic s2Free;
    logic inputOpen;
    logic accept;
    logic runAccept;
    logic lastFire;

    logic signed [PW:0]   pExt;
    logic signed [PW:0]   rndConst;
    logic signed [PW:0]   rndSum;
    logic signed [PW-1:0] rndShift;
    logic signed [PW-1:0] actVal;
    logic [DW-1:0]        satVal;

    // s1 may only advance into s2 when s2 is empty or draining this cycle.
    assign s2Free     = !s2Valid_q || out_ready_i;
    assign inputOpen  = (state_q == S_WARMUP) || ((state_q == S_RUN) && (runCnt_q != lenCfg_q));
    assign in_ready_o = inputOpen && (!s1Valid_q || s2Free);
    assign accept     = in_valid_i && in_ready_o;
    assign runAccept  = accept && (state_q == S_RUN);
    assign lastFire   = s2Valid_q && out_ready_i && s2Last_q;

    assign out_valid_o = s2Valid_q;
    assign out_data_o  = s2Data_q;
    assign out_last_o  = s2Last_q;
    assign busy_o      = (state_q != S_IDLE);

    always_comb begin
        state_d    = state_q;
        warmCnt_d  = warmCnt_q;
        runCnt_d   = runCnt_q;
        lenCfg_d   = lenCfg_q;
        shiftCfg_d = shiftCfg_q;
        actCfg_d   = actCfg_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && (frame_len_i != '0)) begin
                    state_d    = FIRST_STATE;
                    warmCnt_d  = '0;
                    runCnt_d   = '0;
                    lenCfg_d   = frame_len_i;
                    shiftCfg_d = shift_i;
                    actCfg_d   = act_mode_i;
                end
            end
            S_WARMUP: begin
                if (accept) begin
                    if (warmCnt_q == WARM_LAST) begin
                        state_d   = S_RUN;
                        warmCnt_d = '0;
                    end else begin
                        warmCnt_d = warmCnt_q + CW'(1);
                    end
                end
            end
            S_RUN: begin
                if (runAccept) begin
                    runCnt_d = runCnt_q + LW'(1);
                end
                if (lastFire) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Round half toward +inf in PW+1 bits so the bias add can never overflow.
    always_comb begin
        pExt     = {psum_in_i[PW-1], psum_in_i};
        rndConst = '0;
        if (shiftCfg_q != 5'd0) begin
            rndConst = {{PW{1'b0}}, 1'b1} << (shiftCfg_q - 5'd1);
        end
        rndSum   = pExt + rndConst;
        rndShift = PW'(rndSum >>> shiftCfg_q);
    end

    always_comb begin
        case (actCfg_q)
            2'b01:   actVal = (s1Data_q < 0) ? '0 : s1Data_q;
            2'b10:   actVal = (s1Data_q < 0) ? (s1Data_q >>> 3) : s1Data_q;
            default: actVal = s1Data_q;
        endcase
        if (actVal > SAT_MAX) begin
            satVal = SAT_MAX[DW-1:0];
        end else if (actVal < SAT_MIN) begin
            satVal = SAT_MIN[DW-1:0];
        end else begin
            satVal = actVal[DW-1:0];
        end
    end

    always_comb begin
        s1Valid_d = s1Valid_q;
        s1Data_d  = s1Data_q;
        s1Last_d  = s1Last_q;
        s2Valid_d = s2Valid_q;
        s2Data_d  = s2Data_q;
        s2Last_d  = s2Last_q;
        if (s2Free) begin
            s2Valid_d = s1Valid_q;
            s1Valid_d = 1'b0;
            if (s1Valid_q) begin
                s2Data_d = satVal;
                s2Last_d = s1Last_q;
            end
        end
        if (runAccept) begin
            s1Valid_d = 1'b1;
            s1Data_d  = rndShift;
            s1Last_d  = (runCnt_q == lenCfg_q - LW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            warmCnt_q  <= '0;
            runCnt_q   <= '0;
            lenCfg_q   <= '0;
            shiftCfg_q <= '0;
            actCfg_q   <= '0;
            s1Valid_q  <= 1'b0;
            s1Data_q   <= '0;
            s1Last_q   <= 1'b0;
            s2Valid_q  <= 1'b0;
            s2Data_q   <= '0;
            s2Last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            warmCnt_q  <= warmCnt_d;
            runCnt_q   <= runCnt_d;
            lenCfg_q   <= lenCfg_d;
            shiftCfg_q <= shiftCfg_d;
            actCfg_q   <= actCfg_d;
            s1Valid_q  <= s1Valid_d;
            s1Data_q   <= s1Data_d;
            s1Last_q   <= s1Last_d;
            s2Valid_q  <= s2Valid_d;
            s2Data_q   <= s2Data_d;
            s2Last_q   <= s2Last_d;
        end
    end

endmodule

// File: tb/tb_conv1d_requant.sv
// Scoreboard bench for conv1d_requant: directed frames with hand-computed
// results, plus a K=1 instance to exercise the no-warm-up path.
module tb_conv1d_requant;

    typedef struct {
        int data;
        bit last;
    } expT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start1;
    logic [15:0] frameLen;
    logic [4:0]  shift;
    logic [1:0]  actMode;
    logic        inValid, inValid1;
    logic        inReady, inReady1;
    logic [31:0] psumIn;
    logic        outValid, outValid1;
    logic        outReady;
    logic [15:0] outData, outData1;
    logic        outLast, outLast1;
    logic        busy, busy1;

    int  checks = 0;
    int  passed = 0;
    expT sb[$];
    expT sbK1[$];
    expT monE;
    expT monE1;

    always #5 clk = ~clk;

    conv1d_requant #(.DW(16), .K(3), .LW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .frame_len_i(frameLen),
        .shift_i(shift), .act_mode_i(actMode), .in_valid_i(inValid),
        .in_ready_o(inReady), .psum_in_i(psumIn), .out_valid_o(outValid),
        .out_ready_i(outReady), .out_data_o(outData), .out_last_o(outLast),
        .busy_o(busy)
    );

    conv1d_requant #(.DW(16), .K(1), .LW(16)) dutK1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .frame_len_i(frameLen),
        .shift_i(shift), .act_mode_i(actMode), .in_valid_i(inValid1),
        .in_ready_o(inReady1), .psum_in_i(psumIn), .out_valid_o(outValid1),
        .out_ready_i(outReady), .out_data_o(outData1), .out_last_o(outLast1),
        .busy_o(busy1)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Pushes the expectation (unless the beat is a discarded warm-up input)
    // and holds the psum until the DUT takes it.
    task automatic applyStimulus(input bit k1, input int psum, input bit push,
                                 input int expData, input bit expLast);
        expT e;
        int  n;
        bit  ready;
        if (push) begin
            e.data = expData;
            e.last = expLast;
            if (k1) sbK1.push_back(e);
            else    sb.push_back(e);
        end
        psumIn = psum;
        if (k1) inValid1 = 1'b1;
        else    inValid  = 1'b1;
        n = 0;
        ready = 1'b0;
        while (!ready && n < 200) begin
            @(negedge clk);
            ready = k1 ? inReady1 : inReady;
            @(posedge clk);
            #1;
            n++;
        end
        inValid  = 1'b0;
        inValid1 = 1'b0;
        checkOutput("inAccepted", int'(ready), 1);
    endtask

    task automatic startFrame(input bit k1, input int len, input int sh, input int mode);
        frameLen = 16'(len);
        shift    = 5'(sh);
        actMode  = 2'(mode);
        if (k1) start1 = 1'b1;
        else    start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic waitIdle(input bit k1, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((k1 ? busy1 : busy) && n < 1000);
        checkOutput(name, int'(k1 ? busy1 : busy), 0);
        checkOutput("sbDrained", k1 ? sbK1.size() : sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && outValid && outReady) begin
            if (sb.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpectedBeat: got data %0d, required no beat", $signed(outData));
            end else begin
                monE = sb.pop_front();
                checkOutput("outData", $signed(outData), monE.data);
                checkOutput("outLast", int'(outLast), int'(monE.last));
                if (monE.last) checkOutput("busyOnLast", int'(busy), 1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && outValid1 && outReady) begin
            if (sbK1.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpectedBeatK1: got data %0d, required no beat", $signed(outData1));
            end else begin
                monE1 = sbK1.pop_front();
                checkOutput("outDataK1", $signed(outData1), monE1.data);
                checkOutput("outLastK1", int'(outLast1), int'(monE1.last));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0; frameLen = '0; shift = '0;
        actMode = '0; inValid = 1'b0; inValid1 = 1'b0; psumIn = '0; outReady = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstOutValid", int'(outValid), 0);
        checkOutput("rstOutData", int'(outData), 0);
        checkOutput("rstOutLast", int'(outLast), 0);
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstInReady", int'(inReady), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] warm-up frame");
        startFrame(0, 4, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 2, 0, 0, 0);
        applyStimulus(0, 3, 1, 3, 0);
        applyStimulus(0, 4, 1, 4, 0);
        applyStimulus(0, 5, 1, 5, 0);
        applyStimulus(0, 6, 1, 6, 1);
        waitIdle(0, "t1BusyFall");

        $display("[TB] rounding");
        startFrame(0, 4, 4, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 296, 1, 19, 0);
        applyStimulus(0, -296, 1, -18, 0);
        applyStimulus(0, 8, 1, 1, 0);
        applyStimulus(0, 7, 1, 0, 1);
        waitIdle(0, "t2BusyFall");

        $display("[TB] saturation and activation");
        startFrame(0, 2, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 32'h0010_0000, 1, 32767, 0);
        applyStimulus(0, -1000000, 1, -32768, 1);
        waitIdle(0, "t3SatIdle");
        startFrame(0, 2, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, -5, 1, 0, 0);
        applyStimulus(0, 1234, 1, 1234, 1);
        waitIdle(0, "t3ReluIdle");
        startFrame(0, 3, 0, 2);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, -800, 1, -100, 0);
        applyStimulus(0, -1, 1, -1, 0);
        applyStimulus(0, -1000000, 1, -32768, 1);
        waitIdle(0, "t3LeakyIdle");

        $display("[TB] backpressure hold");
        outReady = 1'b0;
        startFrame(0, 8, 0, 0);
        fork
            begin
                applyStimulus(0, 0, 0, 0, 0);
                applyStimulus(0, 0, 0, 0, 0);
                for (int i = 0; i < 8; i++) applyStimulus(0, 100 + i, 1, 100 + i, i == 7);
            end
            begin
                int n;
                n = 0;
                while (!outValid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                checkOutput("bpValidSeen", int'(outValid), 1);
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("bpDataHold", $signed(outData), 100);
                    checkOutput("bpValidHold", int'(outValid), 1);
                    checkOutput("bpInReadyLow", int'(inReady), 0);
                end
                @(posedge clk);
                #1;
                outReady = 1'b1;
            end
        join
        waitIdle(0, "t4HoldIdle");

        $display("[TB] random backpressure");
        startFrame(0, 200, 2, 0);
        fork
            begin
                applyStimulus(0, 0, 0, 0, 0);
                applyStimulus(0, 0, 0, 0, 0);
                for (int i = 0; i < 200; i++) applyStimulus(0, 4 * i + 2, 1, i + 1, i == 199);
            end
            begin
                int n;
                n = 0;
                while (busy && n < 5000) begin
                    @(posedge clk);
                    #1;
                    outReady = 1'($urandom_range(0, 1));
                    n++;
                end
                outReady = 1'b1;
            end
        join
        waitIdle(0, "t4RandIdle");

        $display("[TB] protocol");
        startFrame(0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t5ZeroLenIdle", int'(busy), 0);
        @(posedge clk);
        #1;
        inValid = 1'b1;
        @(negedge clk);
        checkOutput("t5IdleInReady", int'(inReady), 0);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        startFrame(0, 3, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 10, 1, 10, 0);
        startFrame(0, 5, 3, 1);
        checkOutput("t5StillBusy", int'(busy), 1);
        applyStimulus(0, 20, 1, 20, 0);
        applyStimulus(0, -30, 1, -30, 1);
        waitIdle(0, "t5RunStartIgnored");

        $display("[TB] reset mid-frame");
        startFrame(0, 4, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 2, 0, 0, 0);
        applyStimulus(0, 3, 1, 3, 0);
        applyStimulus(0, 4, 1, 4, 0);
        applyStimulus(0, 5, 0, 0, 0);
        applyStimulus(0, 6, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6OutValid", int'(outValid), 0);
        checkOutput("t6OutData", int'(outData), 0);
        checkOutput("t6OutLast", int'(outLast), 0);
        checkOutput("t6Busy", int'(busy), 0);
        checkOutput("t6InReady", int'(inReady), 0);
        checkOutput("t6TwoBeatsSeen", sb.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        startFrame(0, 4, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 2, 0, 0, 0);
        applyStimulus(0, 3, 1, 3, 0);
        applyStimulus(0, 4, 1, 4, 0);
        applyStimulus(0, 5, 1, 5, 0);
        applyStimulus(0, 6, 1, 6, 1);
        waitIdle(0, "t6AfterResetIdle");

        $display("[TB] K=1 instance");
        startFrame(1, 3, 0, 0);
        checkOutput("k1Busy", int'(busy1), 1);
        applyStimulus(1, 10, 1, 10, 0);
        applyStimulus(1, 20, 1, 20, 0);
        applyStimulus(1, 30, 1, 30, 1);
        waitIdle(1, "k1BusyFall");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
